// File: rtl/synth_pkg.sv
// ============================================================================
//  synth_pkg
//  Shared types and default sizes for the voice allocator slice.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package synth_pkg;

  localparam int NUM_NOTES_DEF  = 8;
  localparam int NUM_VOICES_DEF = 4;
  localparam int AGE_W_DEF      = 4;
  localparam int NOTE_W_DEF     = $clog2(NUM_NOTES_DEF);
  localparam int VOICE_W_DEF    = $clog2(NUM_VOICES_DEF);

  typedef logic [NOTE_W_DEF-1:0]  note_idx_t;
  typedef logic [VOICE_W_DEF-1:0] voice_idx_t;
  typedef logic [AGE_W_DEF-1:0]   age_t;

  typedef struct packed {
    logic      active;
    note_idx_t note;
    age_t      age;
  } voice_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/voice_select.sv
// ============================================================================
//  voice_select
//  Combinational search of the voice pool: note hit, lowest free, oldest.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF
) (
  input  voice_t [NUM_VOICES-1:0] voices_i,
  input  note_idx_t               note_i,
  output logic                    hit_o,
  output voice_idx_t              hit_idx_o,
  output logic                    free_o,
  output voice_idx_t              free_idx_o,
  output voice_idx_t              oldest_idx_o
);

  age_t oldest_age;

  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_o       = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    oldest_age   = voices_i[0].age;
    // Descending scan so the lowest matching index is the one left standing.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voices_i[v].active && (voices_i[v].note == note_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = voice_idx_t'(v);
      end
      if (!voices_i[v].active) begin
        free_o     = 1'b1;
        free_idx_o = voice_idx_t'(v);
      end
    end
    // Strict compare keeps ties on the lowest index.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (voices_i[v].age > oldest_age) begin
        oldest_age   = voices_i[v].age;
        oldest_idx_o = voice_idx_t'(v);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
//  voice_allocator
//  Allocates a pool of voices to note triggers; retrigger, free or steal.
//  Optional feature macro: VOICE_STEAL_EN (steal oldest voice instead of drop).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_NOTES  = NUM_NOTES_DEF,
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = $clog2(NUM_NOTES),
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_NOTES-1:0]         gate_in,
  input  logic [NUM_NOTES-1:0]         trigger_in,
  output logic [NUM_VOICES-1:0]        voice_active_out,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out,
  output logic [NUM_VOICES-1:0]        voice_trigger_out,
  output logic                         busy_out,
  output logic                         drop_out
);

  localparam age_t AGE_MAX = age_t'((1 << AGE_W) - 1);

  voice_t [NUM_VOICES-1:0] voices_q, voices_d;
  logic [NUM_NOTES-1:0]    pending_q, pending_d;
  logic [NUM_NOTES-1:0]    live, serviced;
  ctrl_state_t             state_q, state_d;
  logic [NUM_VOICES-1:0]   trig_q, trig_d;
  logic                    drop_q, drop_d;

  logic       svc_valid;
  note_idx_t  svc_note;
  logic       hit, free, alloc;
  voice_idx_t hit_idx, free_idx, oldest_idx, tgt;

  voice_select #(.NUM_VOICES(NUM_VOICES)) u_select (
    .voices_i     (voices_q),
    .note_i       (svc_note),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .free_o       (free),
    .free_idx_o   (free_idx),
    .oldest_idx_o (oldest_idx)
  );

`ifndef VOICE_STEAL_EN
  logic unused_oldest;
  assign unused_oldest = ^oldest_idx;
`endif

  // Pending bits whose gate has already fallen are never served.
  assign live = (state_q == ST_SERVE) ? (pending_q & gate_in) : '0;

  always_comb begin
    svc_valid = 1'b0;
    svc_note  = '0;
    serviced  = '0;
    for (int n = NUM_NOTES - 1; n >= 0; n--) begin
      if (live[n]) begin
        svc_valid = 1'b1;
        svc_note  = note_idx_t'(n);
      end
    end
    if (svc_valid) serviced[svc_note] = 1'b1;
    // A fresh trigger on the bit being served re-arms it.
    pending_d = ((pending_q & ~serviced) | trigger_in) & gate_in;
    state_d   = (pending_d != '0) ? ST_SERVE : ST_IDLE;
  end

  always_comb begin
    voices_d = voices_q;
    trig_d   = '0;
    drop_d   = 1'b0;
    alloc    = 1'b0;
    tgt      = '0;
    if (svc_valid) begin
      if (hit) begin
        alloc = 1'b1;
        tgt   = hit_idx;
      end else if (free) begin
        alloc = 1'b1;
        tgt   = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        alloc = 1'b1;
        tgt   = oldest_idx;
`else
        drop_d = 1'b1;
`endif
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voices_q[v].active && !gate_in[voices_q[v].note])
        voices_d[v].active = 1'b0;
      if (alloc && voices_q[v].active && (voice_idx_t'(v) != tgt) &&
          (voices_q[v].age != AGE_MAX))
        voices_d[v].age = voices_q[v].age + age_t'(1);
    end
    // Applied last so an allocation overrides a same-cycle release.
    if (alloc) begin
      voices_d[tgt].active = 1'b1;
      voices_d[tgt].note   = svc_note;
      voices_d[tgt].age    = '0;
      trig_d[tgt]          = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      voices_q  <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      trig_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      voices_q  <= voices_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      trig_q    <= trig_d;
      drop_q    <= drop_d;
    end
  end

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
      assign voice_active_out[v]                 = voices_q[v].active;
      assign voice_note_out[v*NOTE_W +: NOTE_W]  = voices_q[v].note;
    end
  endgenerate

  assign voice_trigger_out = trig_q;
  assign drop_out          = drop_q;
  assign busy_out          = |pending_q;

endmodule

`default_nettype wire
